// File: rtl/mmu_xlate.sv
// mmu_xlate -- registered virtual-to-physical translation unit (MIPS32 segments).
//
// kseg0/kseg1 map directly; useg/kseg2/kseg3 are looked up in a fully
// associative micro-TLB. A miss is refilled from the main TLB over a
// level req / single-cycle ack handshake. Each accepted request produces
// exactly one resp_valid pulse, except when reset aborts it in flight.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_addr, req_write        virtual address, store flag
//   user_mode, asid            privilege and address space, sampled on accept
//   flush                      invalidate every micro-TLB entry
//   resp_valid                 one-cycle response pulse
//   resp_paddr/uncached/exc    registered response, held between pulses
//   refill_req, refill_vpn     refill request to the main TLB
//   refill_ack, refill_hit     refill answer strobe, main-TLB hit
//   refill_pfn/v/d/g/uc        refill page data

// One micro-TLB entry: storage plus its own match comparator.
module mmu_utlb_entry #(
    parameter int ASID_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [19:0]           wr_vpn,
    input  logic [ASID_WIDTH-1:0] wr_asid,
    input  logic [19:0]           wr_pfn,
    input  logic                  wr_v,
    input  logic                  wr_d,
    input  logic                  wr_g,
    input  logic                  wr_uc,
    input  logic [19:0]           lk_vpn,
    input  logic [ASID_WIDTH-1:0] lk_asid,
    output logic                  lk_hit,
    output logic [19:0]           pfn,
    output logic                  v,
    output logic                  d,
    output logic                  uc
);
    logic                  present;
    logic [19:0]           vpn;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            present <= 1'b0;
            vpn     <= '0;
            asid_q  <= '0;
            pfn     <= '0;
            v       <= 1'b0;
            d       <= 1'b0;
            g       <= 1'b0;
            uc      <= 1'b0;
        end else if (flush) begin
            // flush beats a same-cycle install
            present <= 1'b0;
        end else if (wr_en) begin
            present <= 1'b1;
            vpn     <= wr_vpn;
            asid_q  <= wr_asid;
            pfn     <= wr_pfn;
            v       <= wr_v;
            d       <= wr_d;
            g       <= wr_g;
            uc      <= wr_uc;
        end
    end

    // "present" is entry occupancy; the page V bit is checked after the match.
    assign lk_hit = present && (vpn == lk_vpn) && (g || (asid_q == lk_asid));
endmodule

module mmu_xlate #(
    parameter int UTLB_DEPTH = 4,
    parameter int ASID_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_write,
    input  logic                  user_mode,
    input  logic [ASID_WIDTH-1:0] asid,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [31:0]           resp_paddr,
    output logic                  resp_uncached,
    output logic [2:0]            resp_exc,
    output logic                  refill_req,
    output logic [19:0]           refill_vpn,
    input  logic                  refill_ack,
    input  logic                  refill_hit,
    input  logic [19:0]           refill_pfn,
    input  logic                  refill_v,
    input  logic                  refill_d,
    input  logic                  refill_g,
    input  logic                  refill_uc
);
    localparam int PTR_W = (UTLB_DEPTH > 1) ? $clog2(UTLB_DEPTH) : 1;

    localparam logic [2:0] EXC_NONE    = 3'd0;
    localparam logic [2:0] EXC_ADDR    = 3'd1;
    localparam logic [2:0] EXC_MISS    = 3'd2;
    localparam logic [2:0] EXC_INVALID = 3'd3;
    localparam logic [2:0] EXC_MOD     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  write;
        logic [ASID_WIDTH-1:0] asid;
    } req_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uc;
        logic [2:0]  exc;
    } resp_t;

    state_t     state, state_d;
    req_t       req_q;
    logic [PTR_W-1:0] rr_ptr;

    // V/D permission checks shared by a micro-TLB hit and a refill hit.
    function automatic resp_t page_resp(input logic pv, input logic pd, input logic puc,
                                        input logic wr, input logic [19:0] pfn,
                                        input logic [11:0] off);
        resp_t r;
        r = '0;
        if (!pv)             r.exc = EXC_INVALID;
        else if (wr && !pd)  r.exc = EXC_MOD;
        else begin
            r.paddr = {pfn, off};
            r.uc    = puc;
        end
        return r;
    endfunction

    // ---------------- micro-TLB array ----------------
    logic [UTLB_DEPTH-1:0]        e_hit, e_v, e_d, e_uc, e_wr;
    logic [UTLB_DEPTH-1:0][19:0]  e_pfn;
    logic                         install;

    for (genvar i = 0; i < UTLB_DEPTH; i++) begin : g_ent
        assign e_wr[i] = install && !flush && (rr_ptr == PTR_W'(i));
        mmu_utlb_entry #(.ASID_WIDTH(ASID_WIDTH)) u_ent (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .wr_en   (e_wr[i]),
            .wr_vpn  (req_q.addr[31:12]),
            .wr_asid (req_q.asid),
            .wr_pfn  (refill_pfn),
            .wr_v    (refill_v),
            .wr_d    (refill_d),
            .wr_g    (refill_g),
            .wr_uc   (refill_uc),
            .lk_vpn  (req_addr[31:12]),
            .lk_asid (asid),
            .lk_hit  (e_hit[i]),
            .pfn     (e_pfn[i]),
            .v       (e_v[i]),
            .d       (e_d[i]),
            .uc      (e_uc[i])
        );
    end

    // Lowest matching index wins if a global and a private entry both match.
    logic        lk_hit, lk_v, lk_d, lk_uc;
    logic [19:0] lk_pfn;
    always_comb begin
        lk_hit = 1'b0;
        lk_v   = 1'b0;
        lk_d   = 1'b0;
        lk_uc  = 1'b0;
        lk_pfn = '0;
        for (int i = UTLB_DEPTH - 1; i >= 0; i--) begin
            if (e_hit[i]) begin
                lk_hit = 1'b1;
                lk_v   = e_v[i];
                lk_d   = e_d[i];
                lk_uc  = e_uc[i];
                lk_pfn = e_pfn[i];
            end
        end
    end

    // ---------------- control ----------------
    logic        accept;
    logic        resp_valid_d, refill_req_d;
    logic [19:0] refill_vpn_d;
    resp_t       resp_d;

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        state_d      = state;
        accept       = 1'b0;
        install      = 1'b0;
        resp_valid_d = 1'b0;
        resp_d       = '{paddr: resp_paddr, uc: resp_uncached, exc: resp_exc};
        refill_req_d = refill_req;
        refill_vpn_d = refill_vpn;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (user_mode && req_addr[31]) begin
                        resp_valid_d = 1'b1;
                        resp_d       = '{paddr: 32'd0, uc: 1'b0, exc: EXC_ADDR};
                    end else if (req_addr[31:30] == 2'b10) begin
                        // kseg0 / kseg1: bit 29 selects the uncached window
                        resp_valid_d = 1'b1;
                        resp_d       = '{paddr: {3'b000, req_addr[28:0]},
                                         uc: req_addr[29], exc: EXC_NONE};
                    end else if (lk_hit) begin
                        resp_valid_d = 1'b1;
                        resp_d       = page_resp(lk_v, lk_d, lk_uc, req_write,
                                                 lk_pfn, req_addr[11:0]);
                    end else begin
                        state_d      = ST_REFILL;
                        refill_req_d = 1'b1;
                        refill_vpn_d = req_addr[31:12];
                    end
                end
            end
            ST_REFILL: begin
                if (refill_ack) begin
                    state_d      = ST_RESP;
                    refill_req_d = 1'b0;
                    resp_valid_d = 1'b1;
                    if (refill_hit) begin
                        install = 1'b1;
                        resp_d  = page_resp(refill_v, refill_d, refill_uc, req_q.write,
                                            refill_pfn, req_q.addr[11:0]);
                    end else begin
                        resp_d  = '{paddr: 32'd0, uc: 1'b0, exc: EXC_MISS};
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q         <= '0;
            rr_ptr        <= '0;
            resp_valid    <= 1'b0;
            resp_paddr    <= '0;
            resp_uncached <= 1'b0;
            resp_exc      <= EXC_NONE;
            refill_req    <= 1'b0;
            refill_vpn    <= '0;
        end else begin
            if (accept) req_q <= '{addr: req_addr, write: req_write, asid: asid};
            if (flush)        rr_ptr <= '0;
            else if (install) rr_ptr <= rr_ptr + PTR_W'(1);
            resp_valid    <= resp_valid_d;
            resp_paddr    <= resp_d.paddr;
            resp_uncached <= resp_d.uc;
            resp_exc      <= resp_d.exc;
            refill_req    <= refill_req_d;
            refill_vpn    <= refill_vpn_d;
        end
    end
endmodule

// File: tb/tb_mmu_xlate.sv
// Testbench for mmu_xlate: directed cases followed by random traffic,
// checked against a table-based model of the micro-TLB and segment rules.
module tb_mmu_xlate;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, user_mode = 1'b0, flush = 1'b0;
    logic [31:0] req_addr = '0;
    logic [7:0]  asid = '0;
    logic        req_ready, resp_valid, resp_uncached, refill_req;
    logic [31:0] resp_paddr;
    logic [2:0]  resp_exc;
    logic [19:0] refill_vpn;
    logic        refill_ack = 1'b0, refill_hit = 1'b0;
    logic [19:0] refill_pfn = '0;
    logic        refill_v = 1'b0, refill_d = 1'b0, refill_g = 1'b0, refill_uc = 1'b0;

    always #5 clk = ~clk;

    mmu_xlate #(.UTLB_DEPTH(DEPTH), .ASID_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .user_mode(user_mode), .asid(asid),
        .flush(flush), .resp_valid(resp_valid), .resp_paddr(resp_paddr),
        .resp_uncached(resp_uncached), .resp_exc(resp_exc), .refill_req(refill_req),
        .refill_vpn(refill_vpn), .refill_ack(refill_ack), .refill_hit(refill_hit),
        .refill_pfn(refill_pfn), .refill_v(refill_v), .refill_d(refill_d),
        .refill_g(refill_g), .refill_uc(refill_uc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Micro-TLB as a plain table with a round-robin slot counter.
    bit          m_vld [DEPTH];
    logic [19:0] m_vpn [DEPTH];
    logic [7:0]  m_asid[DEPTH];
    logic [19:0] m_pfn [DEPTH];
    bit          m_v[DEPTH], m_d[DEPTH], m_g[DEPTH], m_uc[DEPTH];
    int          m_rr = 0;

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        m_rr = 0;
    endfunction

    function automatic int m_find(input logic [19:0] vpn, input logic [7:0] as);
        for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && m_vpn[i] == vpn && (m_g[i] || m_asid[i] == as)) return i;
        return -1;
    endfunction

    // Expected response for a mapped page from its V/D/C bits.
    task automatic page_exp(input bit v, input bit d, input bit uc, input bit w,
                            input logic [19:0] pfn, input logic [11:0] off,
                            output logic [31:0] pa, output logic puc, output logic [2:0] ex);
        pa = 0; puc = 0; ex = 0;
        if (!v)          ex = 3;
        else if (w && !d) ex = 4;
        else begin pa = pfn * 32'h1000 + off; puc = uc; end
    endtask

    // One full transaction: accept, optional refill after dly cycles, response.
    task automatic xact(input logic [31:0] a, input logic w, input logic u, input logic [7:0] as,
                        input int dly, input logic rh, input logic [19:0] pfn,
                        input logic v, input logic d, input logic g, input logic uc,
                        input logic fl_acc, input logic fl_ack,
                        output logic [31:0] o_pa, output logic o_uc, output logic [2:0] o_exc,
                        output logic o_ref);
        logic [31:0] e_pa; logic e_uc; logic [2:0] e_exc; bit need_ref; int idx;
        need_ref = 0; e_pa = 0; e_uc = 0; e_exc = 0;
        if (u && a[31]) e_exc = 1;
        else if (a[31:30] == 2'b10) begin e_pa = a & 32'h1FFF_FFFF; e_uc = a[29]; end
        else begin
            idx = m_find(a[31:12], as);
            if (idx >= 0) page_exp(m_v[idx], m_d[idx], m_uc[idx], w, m_pfn[idx], a[11:0],
                                   e_pa, e_uc, e_exc);
            else need_ref = 1;
        end
        if (fl_acc) m_clear();

        chk("ready_before_accept", req_ready, 1);
        req_valid = 1; req_addr = a; req_write = w; user_mode = u; asid = as; flush = fl_acc;
        @(posedge clk); #1;
        // scramble inputs: the DUT must work from the latched copy
        req_valid = 0; flush = 0; req_addr = $urandom; req_write = ~w; asid = ~as;
        user_mode = $urandom_range(0, 1);
        o_ref = refill_req;
        if (!need_ref) begin
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_no_refill", refill_req, 0);
        end else begin
            chk("miss_refill_req", refill_req, 1);
            chk("miss_refill_vpn", refill_vpn, a[31:12]);
            chk("miss_no_early_resp", resp_valid, 0);
            for (int k = 0; k < dly; k++) begin
                @(posedge clk); #1;
                chk("refill_wait_req", refill_req, 1);
                chk("refill_wait_noresp", resp_valid, 0);
            end
            refill_ack = 1; refill_hit = rh; refill_pfn = pfn;
            refill_v = v; refill_d = d; refill_g = g; refill_uc = uc; flush = fl_ack;
            @(posedge clk); #1;
            refill_ack = 0; flush = 0; refill_hit = $urandom_range(0, 1); refill_pfn = $urandom;
            chk("ack_drop_req", refill_req, 0);
            chk("ack_resp_valid", resp_valid, 1);
            if (rh) begin
                page_exp(v, d, uc, w, pfn, a[11:0], e_pa, e_uc, e_exc);
                if (!fl_ack) begin
                    m_vld[m_rr] = 1; m_vpn[m_rr] = a[31:12]; m_asid[m_rr] = as;
                    m_pfn[m_rr] = pfn; m_v[m_rr] = v; m_d[m_rr] = d; m_g[m_rr] = g;
                    m_uc[m_rr] = uc; m_rr = (m_rr + 1) % DEPTH;
                end
            end else e_exc = 2;
            if (fl_ack) m_clear();
        end
        chk("resp_paddr", resp_paddr, e_pa);
        chk("resp_uncached", resp_uncached, e_uc);
        chk("resp_exc", resp_exc, e_exc);
        o_pa = resp_paddr; o_uc = resp_uncached; o_exc = resp_exc;
        @(posedge clk); #1;
        chk("resp_one_pulse", resp_valid, 0);
        chk("resp_hold_paddr", resp_paddr, e_pa);
    endtask

    task automatic do_flush();
        flush = 1; @(posedge clk); #1; flush = 0;
        m_clear();
    endtask

    logic [31:0] pa; logic puc; logic [2:0] ex; logic rf;
    logic [19:0] pool[8];

    initial begin
        pool = '{20'h00400, 20'h00401, 20'h00402, 20'h00403, 20'h00404, 20'h00405,
                 20'hC0000, 20'hE0001};
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_paddr", resp_paddr, 0);
        chk("rst_exc", resp_exc, 0);
        chk("rst_refill_req", refill_req, 0);
        chk("rst_refill_vpn", refill_vpn, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // 1: kseg0 / kseg1 direct mapping
        xact(32'h8000_1234, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t1_kseg0_pa", pa, 32'h0000_1234); chk("t1_kseg0_uc", puc, 0);
        xact(32'hA000_0010, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t1_kseg1_pa", pa, 32'h0000_0010); chk("t1_kseg1_uc", puc, 1);

        // 2: user access to kernel space
        xact(32'h8000_0000, 0, 1, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t2_exc", ex, 1); chk("t2_pa", pa, 0); chk("t2_no_refill", rf, 0);

        // 3: refill after 5 cycles, then hit at latency 1
        xact(32'h0040_0008, 0, 1, 8'd1, 5, 1, 20'h12345, 1, 1, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t3_refilled", rf, 1); chk("t3_pa", pa, 32'h1234_5008);
        xact(32'h0040_0ABC, 0, 1, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t3_hit", rf, 0); chk("t3_hit_pa", pa, 32'h1234_5ABC);

        // 4: clean page store -> TLB_MOD; main-TLB miss -> TLB_MISS, then refills again
        xact(32'h0050_0004, 1, 0, 8'd1, 1, 1, 20'h00777, 1, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t4_mod", ex, 4);
        xact(32'h0050_0004, 1, 0, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t4_mod_hit", ex, 4); chk("t4_mod_hit_noref", rf, 0);
        xact(32'h0060_0000, 0, 0, 8'd1, 2, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t4_miss", ex, 2);
        xact(32'h0060_0000, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t4_rerefill", rf, 1);

        // 5: round-robin eviction and ASID matching
        do_flush();
        for (int i = 0; i <= DEPTH; i++)
            xact({12'h010, 8'(i), 12'h0}, 0, 0, 8'd1, 0, 1, 20'h20000 + 20'(i), 1, 1, 0, 0,
                 0, 0, pa, puc, ex, rf);
        for (int i = 1; i <= DEPTH; i++) begin
            xact({12'h010, 8'(i), 12'h0}, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
            chk("t5_kept_hit", rf, 0);
            chk("t5_kept_pa", pa, 32'h2000_0000 + i * 32'h1000);
        end
        xact(32'h0100_0000, 0, 0, 8'd1, 0, 1, 20'h20000, 1, 1, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t5_evicted_miss", rf, 1);
        xact(32'h0200_0000, 0, 0, 8'd1, 0, 1, 20'h30000, 1, 1, 0, 0, 0, 0, pa, puc, ex, rf);
        xact(32'h0200_0000, 0, 0, 8'd2, 0, 1, 20'h30001, 1, 1, 0, 1, 0, 0, pa, puc, ex, rf);
        chk("t5_asid_g0_miss", rf, 1); chk("t5_uc_pa", pa, 32'h3000_1000);
        xact(32'h0300_0000, 0, 0, 8'd1, 0, 1, 20'h40000, 1, 1, 1, 0, 0, 0, pa, puc, ex, rf);
        xact(32'h0300_0000, 0, 0, 8'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t5_asid_g1_hit", rf, 0);

        // 6: flush with install, flush in the accept cycle, reset mid-refill
        xact(32'h0400_0040, 0, 0, 8'd1, 1, 1, 20'h50000, 1, 1, 0, 0, 0, 1, pa, puc, ex, rf);
        chk("t6_flush_resp_pa", pa, 32'h5000_0040);
        xact(32'h0400_0040, 0, 0, 8'd1, 0, 1, 20'h50000, 1, 1, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t6_flushed_miss", rf, 1);
        xact(32'h0400_0040, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, pa, puc, ex, rf);
        chk("t6_acc_flush_old_hit", rf, 0);
        xact(32'h0400_0040, 0, 0, 8'd1, 0, 1, 20'h50000, 1, 1, 0, 0, 0, 0, pa, puc, ex, rf);
        chk("t6_acc_flush_then_miss", rf, 1);
        req_valid = 1; req_addr = 32'h0700_0000; asid = 1; user_mode = 0;
        @(posedge clk); #1; req_valid = 0;
        chk("t6_rst_refill_req", refill_req, 1);
        #2 rst_n = 0; #2;
        chk("t6_rst_drop_req", refill_req, 0);
        @(posedge clk); #1; rst_n = 1; m_clear();
        for (int k = 0; k < 4; k++) begin
            chk("t6_rst_no_resp", resp_valid, 0);
            chk("t6_rst_ready", req_ready, 1);
            refill_ack = (k == 1); refill_hit = 1; refill_pfn = 20'h7;
            refill_v = 1; refill_d = 1; refill_g = 1;
            @(posedge clk); #1;
        end
        refill_ack = 0;

        // random traffic; stray acks outside REFILL must be ignored
        for (int n = 0; n < 80; n++) begin
            int sel; logic [31:0] a; logic [7:0] as; logic u;
            sel = $urandom_range(0, 9);
            if (sel == 0) do_flush();
            if (sel == 1) begin
                refill_ack = 1; refill_hit = 1; refill_pfn = $urandom;
                @(posedge clk); #1; refill_ack = 0;
                chk("stray_ack_noresp", resp_valid, 0);
            end
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
                1:       a = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
                default: a = {pool[$urandom_range(0, 7)], 12'($urandom)};
            endcase
            u  = ($urandom_range(0, 3) == 0);
            as = 8'($urandom_range(1, 2));
            xact(a, 1'($urandom), u, as, $urandom_range(0, 3), ($urandom_range(0, 4) != 0),
                 20'($urandom), 1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 pa, puc, ex, rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
